// File: rtl/sdram_burst_writer.sv
// Stream-to-Avalon-MM burst writer: buffers 16-bit words in a FIFO and emits
// fixed-length write bursts at a linearly advancing address; flush drains the tail.
module sdram_burst_writer #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 22,
  parameter int                BURST      = 256,
  parameter int                FIFO_DEPTH = 512,
  parameter logic [ADDR_W-1:0] ADDR_BASE  = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        flush,
  output logic [ADDR_W-1:0]           address,
  output logic [8:0]                  burstcount,
  output logic                        write,
  output logic [DATA_W-1:0]           writedata,
  output logic [DATA_W/8-1:0]         byteenable,
  input  logic                        waitrequest,
  output logic                        busy,
  output logic                        burst_done,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, ARM, BEAT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]   next_addr;
  logic [8:0]          beats_left;
  logic                flush_pending;
  logic                push, pop, accept, last;
  logic [LW-1:0]       arm_cnt;

  assign byteenable = '1;
  assign s_ready    = (level < LW'(FIFO_DEPTH));
  assign push       = s_valid & s_ready;
  assign accept     = write & ~waitrequest;
  assign last       = (beats_left == 9'd1);
  // the word in writedata is already out of the FIFO, so every beat after the
  // first pops on the acceptance of its predecessor
  assign pop        = (state == ARM) | ((state == BEAT) & accept & ~last);
  assign arm_cnt    = (level > LW'(BURST)) ? LW'(BURST) : level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      flush_pending <= 1'b0;
      next_addr     <= ADDR_BASE;
      address       <= ADDR_BASE;
      burstcount    <= '0;
      beats_left    <= '0;
      write         <= 1'b0;
      writedata     <= '0;
      busy          <= 1'b0;
      burst_done    <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      level      <= level + LW'(push) - LW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        writedata <= mem[rd_ptr];
      end
      case (state)
        IDLE: begin
          if (level >= LW'(BURST) || (flush_pending && level != '0)) state <= ARM;
          else if (level == '0) flush_pending <= 1'b0;
        end
        ARM: begin
          burstcount <= 9'(arm_cnt);
          beats_left <= 9'(arm_cnt);
          address    <= next_addr;
          write      <= 1'b1;
          busy       <= 1'b1;
          if (arm_cnt == level) flush_pending <= 1'b0;
          state      <= BEAT;
        end
        BEAT: begin
          if (accept) begin
            if (last) begin
              write      <= 1'b0;
              busy       <= 1'b0;
              burst_done <= 1'b1;
              next_addr  <= next_addr + ADDR_W'(burstcount);
              state      <= IDLE;
            end else begin
              beats_left <= beats_left - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // a new flush request beats a same-cycle clear
      if (flush) flush_pending <= 1'b1;
    end
  end
endmodule
